// File: rtl/neuron_layer_sched_pkg.sv
// Shared types and constants for the time-multiplexed Q3.4 neuron layer.
// Holds the FSM state enum, config field selects and the sigmoid step thresholds.
package nn_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_FRAC_BITS  = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL,
    SHIFT,
    ADD,
    ACT,
    STORE,
    DONE
  } state_t;

  // Low two bits of cfg_addr pick the per-neuron field; 3 is ignored.
  localparam logic [1:0] SEL_W1   = 2'd0;
  localparam logic [1:0] SEL_W2   = 2'd1;
  localparam logic [1:0] SEL_BIAS = 2'd2;

  // The sigmoid output is an integer 0..16, so it steps up 16 times.
  localparam int SIG_STEPS = 16;

  // Smallest ACC at which round(16*sigmoid(a/16)) reaches k, i.e. ceil(16*ln((2k-1)/(33-2k))).
  function automatic int sig_threshold(input int k);
    case (k)
      1:       sig_threshold = -54;
      2:       sig_threshold = -36;
      3:       sig_threshold = -26;
      4:       sig_threshold = -20;
      5:       sig_threshold = -15;
      6:       sig_threshold = -10;
      7:       sig_threshold = -6;
      8:       sig_threshold = -2;
      9:       sig_threshold = 3;
      10:      sig_threshold = 7;
      11:      sig_threshold = 11;
      12:      sig_threshold = 16;
      13:      sig_threshold = 21;
      14:      sig_threshold = 27;
      15:      sig_threshold = 37;
      default: sig_threshold = 55;
    endcase
  endfunction

endpackage

// File: rtl/neuron_layer_sched_if.sv
// Handshake, config and result bus of the neuron layer scheduler.
// master = the side feeding samples and config; slave = the layer itself.
interface neuron_layer_sched_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_NEURONS = 4
);
  localparam int ADDR_WIDTH = $clog2(NUM_NEURONS) + 2;

  logic                                in_valid;
  logic                                in_ready;
  logic signed [DATA_WIDTH-1:0]        X1;
  logic signed [DATA_WIDTH-1:0]        X2;

  logic                                cfg_we;
  logic [ADDR_WIDTH-1:0]               cfg_addr;
  logic signed [DATA_WIDTH-1:0]        cfg_data;

  logic                                out_valid;
  logic                                out_ready;
  logic [NUM_NEURONS*DATA_WIDTH-1:0]   Y;

  modport master (
    output in_valid, X1, X2, cfg_we, cfg_addr, cfg_data, out_ready,
    input  in_ready, out_valid, Y
  );

  modport slave (
    input  in_valid, X1, X2, cfg_we, cfg_addr, cfg_data, out_ready,
    output in_ready, out_valid, Y
  );

endinterface

// File: rtl/neuron_layer_sched_sigmoid.sv
// Combinational Q3.4 sigmoid: ACC in, round(16/(1+exp(-a/16))) out (0..16).
// Built as a thermometer of fixed thresholds so it saturates at 0 and 16 naturally.
module sigmoid_q34
  import nn_pkg::*;
#(
  parameter int ACC_WIDTH = DEFAULT_DATA_WIDTH + 2,
  parameter int OUT_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic        [OUT_WIDTH-1:0] y
);

  logic [SIG_STEPS-1:0] step_hit;

  genvar gi;
  generate
    for (gi = 0; gi < SIG_STEPS; gi++) begin : g_step
      localparam logic signed [ACC_WIDTH-1:0] TH = ACC_WIDTH'(sig_threshold(gi + 1));
      assign step_hit[gi] = (acc >= TH);
    end
  endgenerate

  always_comb begin
    y = '0;
    for (int i = 0; i < SIG_STEPS; i++) begin
      y = y + OUT_WIDTH'(step_hit[i]);
    end
  end

endmodule

// File: rtl/neuron_layer_sched.sv
// Two-input neuron layer: NUM_NEURONS neurons share one multiply/shift/add/sigmoid
// datapath, stepping through LOAD, then MUL..STORE once per neuron.
module neuron_layer_sched
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int FRAC_BITS   = DEFAULT_FRAC_BITS,
  parameter int NUM_NEURONS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 En,
  neuron_layer_sched_if.slave  bus,
  output logic                 busy
);

  localparam int ADDR_WIDTH = $clog2(NUM_NEURONS) + 2;
  localparam int SEL_IDX_W  = ADDR_WIDTH - 2;
  localparam int IDX_WIDTH  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int ACC_WIDTH  = DATA_WIDTH + 2;
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  localparam logic [IDX_WIDTH-1:0]         LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);
  localparam logic signed [DATA_WIDTH-1:0] W_ONE    = DATA_WIDTH'(1 << FRAC_BITS);

  state_t state_reg;
  state_t state_next;

  logic [IDX_WIDTH-1:0]          idx_reg;
  logic signed [DATA_WIDTH-1:0]  x1_reg;
  logic signed [DATA_WIDTH-1:0]  x2_reg;
  logic signed [PROD_WIDTH-1:0]  p1_reg;
  logic signed [PROD_WIDTH-1:0]  p2_reg;
  logic signed [ACC_WIDTH-1:0]   acc_reg;
  logic signed [ACC_WIDTH-1:0]   acc_next;
  logic [DATA_WIDTH-1:0]         yb_reg;
  logic [DATA_WIDTH-1:0]         yb_next;
  logic [DATA_WIDTH-1:0]         y_reg [NUM_NEURONS];

  logic signed [DATA_WIDTH-1:0]  w1_reg   [NUM_NEURONS];
  logic signed [DATA_WIDTH-1:0]  w2_reg   [NUM_NEURONS];
  logic signed [DATA_WIDTH-1:0]  bias_reg [NUM_NEURONS];

  logic                          cfg_en;
  logic [SEL_IDX_W-1:0]          cfg_idx;
  logic [1:0]                    cfg_sel;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else if (En) begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    case (state_reg)
      IDLE: begin
        busy         = 1'b0;
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_next = LOAD;
        end
      end
      LOAD:  state_next = MUL;
      MUL:   state_next = SHIFT;
      SHIFT: state_next = ADD;
      ADD:   state_next = ACT;
      ACT:   state_next = STORE;
      STORE: state_next = (idx_reg == LAST_IDX) ? DONE : MUL;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- config
  assign cfg_en  = En && bus.cfg_we && (state_reg == IDLE);
  assign cfg_idx = bus.cfg_addr[ADDR_WIDTH-1:2];
  assign cfg_sel = bus.cfg_addr[1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        w1_reg[i]   <= W_ONE;
        w2_reg[i]   <= W_ONE;
        bias_reg[i] <= W_ONE;
      end
    end else if (cfg_en) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (cfg_idx == SEL_IDX_W'(i)) begin
          case (cfg_sel)
            SEL_W1:   w1_reg[i]   <= bus.cfg_data;
            SEL_W2:   w2_reg[i]   <= bus.cfg_data;
            SEL_BIAS: bias_reg[i] <= bus.cfg_data;
            default:  ;
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------- datapath
  // Only the low DATA_WIDTH bits of each scaled product contribute, so overflow wraps.
  assign acc_next = ACC_WIDTH'(bias_reg[idx_reg])
                  + ACC_WIDTH'($signed(p1_reg[DATA_WIDTH-1:0]))
                  + ACC_WIDTH'($signed(p2_reg[DATA_WIDTH-1:0]));

  sigmoid_q34 #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (DATA_WIDTH)
  ) u_sigmoid (
    .acc (acc_reg),
    .y   (yb_next)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_reg <= '0;
      x1_reg  <= '0;
      x2_reg  <= '0;
      p1_reg  <= '0;
      p2_reg  <= '0;
      acc_reg <= '0;
      yb_reg  <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        y_reg[i] <= '0;
      end
    end else if (En) begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            x1_reg  <= bus.X1;
            x2_reg  <= bus.X2;
            idx_reg <= '0;
          end
        end
        MUL: begin
          p1_reg <= PROD_WIDTH'(x1_reg) * PROD_WIDTH'(w1_reg[idx_reg]);
          p2_reg <= PROD_WIDTH'(x2_reg) * PROD_WIDTH'(w2_reg[idx_reg]);
        end
        SHIFT: begin
          p1_reg <= p1_reg >>> FRAC_BITS;
          p2_reg <= p2_reg >>> FRAC_BITS;
        end
        ADD:   acc_reg <= acc_next;
        ACT:   yb_reg  <= yb_next;
        STORE: begin
          y_reg[idx_reg] <= yb_reg;
          if (idx_reg != LAST_IDX) begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_y
      assign bus.Y[gi*DATA_WIDTH +: DATA_WIDTH] = y_reg[gi];
    end
  endgenerate

endmodule
